// File: rtl/ysyx_24080006_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_24080006_pkg
// Shared constants for the instruction fetch unit:
//   - IFU state encoding (IDLE / REQ / WAIT / HOLD)
//   - default reset PC and default illegal-instruction word
// No ports (package).
// ----------------------------------------------------------------------------
package ysyx_24080006_pkg;

    // IFU state encoding. Plain 2-bit constants so that the state register
    // stays a legacy-compatible logic vector.
    localparam logic [1:0] IFU_S_IDLE = 2'd0;  // waiting for a writeback token
    localparam logic [1:0] IFU_S_REQ  = 2'd1;  // issuing the memory read
    localparam logic [1:0] IFU_S_WAIT = 2'd2;  // waiting for the read response
    localparam logic [1:0] IFU_S_HOLD = 2'd3;  // presenting the word to decode

    localparam logic [31:0] RESET_PC_DEFAULT     = 32'h8000_0000;
    localparam logic [31:0] ILLEGAL_INST_DEFAULT = 32'h0000_0000;

endpackage : ysyx_24080006_pkg

// File: rtl/ysyx_24080006_ifu_if.sv
// ----------------------------------------------------------------------------
// ysyx_24080006_ifu_if
// Bundles the three handshakes around the IFU:
//   wbu_*  : writeback token in (valid/ready) with the redirect information
//   mem_*  : instruction memory read port (single outstanding request)
//   idu_*  : fetched-instruction handoff to decode (valid/ready)
// Modports:
//   master : the IFU side
//   slave  : the environment (WBU, instruction memory, IDU)
// ----------------------------------------------------------------------------
interface ysyx_24080006_ifu_if;

    // Writeback token
    logic        wbu_valid;
    logic        wbu_ready;
    logic [31:0] wbu_dnpc;
    logic        wbu_jump;
    logic        wbu_branch;

    // Instruction memory read port
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_err;

    // Decode handoff
    logic        idu_valid;
    logic        idu_ready;
    logic [31:0] idu_inst;
    logic [31:0] idu_pc;
    logic        idu_err;

    modport master (
        input  wbu_valid, wbu_dnpc, wbu_jump, wbu_branch,
        output wbu_ready,
        output mem_req, mem_addr,
        input  mem_rvalid, mem_rdata, mem_err,
        output idu_valid, idu_inst, idu_pc, idu_err,
        input  idu_ready
    );

    modport slave (
        output wbu_valid, wbu_dnpc, wbu_jump, wbu_branch,
        input  wbu_ready,
        input  mem_req, mem_addr,
        output mem_rvalid, mem_rdata, mem_err,
        input  idu_valid, idu_inst, idu_pc, idu_err,
        output idu_ready
    );

endinterface : ysyx_24080006_ifu_if

// File: rtl/ysyx_24080006_ifu.sv
// ----------------------------------------------------------------------------
// ysyx_24080006_ifu
// Instruction fetch unit. Accepts one writeback token, computes the next PC,
// reads one instruction word from memory and hands it to decode, then waits
// for the next token. Exactly one fetch is in flight at any time.
// Ports:
//   clock    : system clock, rising edge
//   reset    : synchronous, active-high
//   bus      : ysyx_24080006_ifu_if.master (wbu_*, mem_*, idu_* handshakes)
//   inst_cnt : number of instructions accepted by decode (wraps at 2^32)
// Parameters:
//   RESET_PC     : address of the first fetch after reset
//   ILLEGAL_INST : word presented to decode when the fetch fails
// ----------------------------------------------------------------------------
module ysyx_24080006_ifu
    import ysyx_24080006_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = RESET_PC_DEFAULT,
    parameter logic [31:0] ILLEGAL_INST = ILLEGAL_INST_DEFAULT
) (
    input  logic                       clock,
    input  logic                       reset,
    ysyx_24080006_ifu_if.master        bus,
    output logic [31:0]                inst_cnt
);

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q,    pc_d;
    logic        first_q, first_d;   // no token accepted since reset yet
    logic [31:0] inst_q,  inst_d;
    logic        err_q,   err_d;
    logic [31:0] cnt_q,   cnt_d;

    logic pc_misaligned;
    assign pc_misaligned = (pc_q[1:0] != 2'b00);

    // ------------------------------------------------------------------------
    // Next-state logic, including the inline next-pc mux
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        state_d = state_q;
        pc_d    = pc_q;
        first_d = first_q;
        inst_d  = inst_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        case (state_q)
            IFU_S_IDLE: begin
                if (bus.wbu_valid) begin
                    state_d = IFU_S_REQ;
                    first_d = 1'b0;
                    // The token after reset only starts the machine; the
                    // reset PC itself is the first address fetched.
                    if (first_q) begin
                        pc_d = pc_q;
                    end else if (bus.wbu_jump || bus.wbu_branch) begin
                        pc_d = bus.wbu_dnpc;
                    end else begin
                        pc_d = pc_q + 32'd4;
                    end
                end
            end

            IFU_S_REQ: begin
                // A misaligned PC never reaches memory; it is reported to
                // decode as a faulting fetch instead.
                if (pc_misaligned) begin
                    state_d = IFU_S_HOLD;
                    inst_d  = ILLEGAL_INST;
                    err_d   = 1'b1;
                end else begin
                    state_d = IFU_S_WAIT;
                end
            end

            IFU_S_WAIT: begin
                // The response is only looked at here, so a stray or late
                // rvalid in any other state has no effect.
                if (bus.mem_rvalid) begin
                    state_d = IFU_S_HOLD;
                    inst_d  = bus.mem_err ? ILLEGAL_INST : bus.mem_rdata;
                    err_d   = bus.mem_err;
                end
            end

            IFU_S_HOLD: begin
                if (bus.idu_ready) begin
                    state_d = IFU_S_IDLE;
                    cnt_d   = cnt_q + 32'd1;
                end
            end

            default: begin
                state_d = IFU_S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (reset) begin
            state_q <= IFU_S_IDLE;
            pc_q    <= RESET_PC;
            first_q <= 1'b1;
            inst_q  <= 32'h0000_0000;
            err_q   <= 1'b0;
            cnt_q   <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            first_q <= first_d;
            inst_q  <= inst_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: handshake strobes are decoded from registers only
    // ------------------------------------------------------------------------
    assign bus.wbu_ready = (state_q == IFU_S_IDLE);
    assign bus.mem_req   = (state_q == IFU_S_REQ) && !pc_misaligned;
    assign bus.mem_addr  = pc_q;
    assign bus.idu_valid = (state_q == IFU_S_HOLD);
    assign bus.idu_inst  = inst_q;
    assign bus.idu_pc    = pc_q;
    assign bus.idu_err   = err_q;
    assign inst_cnt      = cnt_q;

endmodule : ysyx_24080006_ifu

// File: tb/tb_ysyx_24080006_ifu.sv
// ----------------------------------------------------------------------------
// tb_ysyx_24080006_ifu
// Directed self-checking bench for ysyx_24080006_ifu. Inputs change and
// outputs are sampled on the falling edge; the DUT acts on the rising edge.
// ----------------------------------------------------------------------------
module tb_ysyx_24080006_ifu;

    logic        clock;
    logic        reset;
    logic [31:0] inst_cnt;

    int tests_run;
    int tests_failed;
    int exp_cnt;

    ysyx_24080006_ifu_if bus ();

    ysyx_24080006_ifu #(
        .RESET_PC     (32'h8000_0000),
        .ILLEGAL_INST (32'h0000_0000)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus),
        .inst_cnt (inst_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // One complete token -> fetch -> decode transaction.
    //   exp_addr : hand-computed fetch address
    //   wait_cyc : extra WAIT cycles before the memory responds
    //   hold_cyc : cycles decode stalls (stray rvalid pulsed each stall cycle)
    task automatic fetch(input string tag, input logic jump, input logic branch,
                         input logic [31:0] dnpc, input logic [31:0] exp_addr,
                         input logic [31:0] rdata, input logic merr,
                         input int wait_cyc, input int hold_cyc);
        logic        misaligned;
        logic [31:0] exp_inst;
        logic        exp_err;
        misaligned = (exp_addr[1:0] != 2'b00);
        exp_err    = misaligned || merr;
        exp_inst   = exp_err ? 32'h0000_0000 : rdata;

        check({tag, "_wbu_ready_idle"}, {31'd0, bus.wbu_ready}, 32'd1);
        bus.wbu_valid  = 1'b1;
        bus.wbu_jump   = jump;
        bus.wbu_branch = branch;
        bus.wbu_dnpc   = dnpc;
        @(negedge clock);
        bus.wbu_valid  = 1'b0;
        bus.wbu_jump   = 1'b0;
        bus.wbu_branch = 1'b0;
        bus.wbu_dnpc   = 32'h0;

        // REQ cycle
        check({tag, "_mem_req"}, {31'd0, bus.mem_req}, {31'd0, !misaligned});
        check({tag, "_mem_addr"}, bus.mem_addr, exp_addr);
        check({tag, "_wbu_ready_busy"}, {31'd0, bus.wbu_ready}, 32'd0);
        @(negedge clock);

        if (!misaligned) begin
            // WAIT cycles
            for (int i = 0; i < wait_cyc; i++) begin
                check({tag, "_wait_req"}, {31'd0, bus.mem_req}, 32'd0);
                check({tag, "_wait_valid"}, {31'd0, bus.idu_valid}, 32'd0);
                @(negedge clock);
            end
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = rdata;
            bus.mem_err    = merr;
            @(negedge clock);
            bus.mem_rvalid = 1'b0;
            bus.mem_err    = 1'b0;
        end

        // HOLD cycles
        for (int i = 0; i <= hold_cyc; i++) begin
            check({tag, "_idu_valid"}, {31'd0, bus.idu_valid}, 32'd1);
            check({tag, "_idu_inst"}, bus.idu_inst, exp_inst);
            check({tag, "_idu_pc"}, bus.idu_pc, exp_addr);
            check({tag, "_idu_err"}, {31'd0, bus.idu_err}, {31'd0, exp_err});
            check({tag, "_hold_wbu_ready"}, {31'd0, bus.wbu_ready}, 32'd0);
            if (i < hold_cyc) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = ~rdata;
                @(negedge clock);
                bus.mem_rvalid = 1'b0;
            end else begin
                bus.idu_ready = 1'b1;
                @(negedge clock);
                bus.idu_ready = 1'b0;
            end
        end

        exp_cnt++;
        check({tag, "_inst_cnt"}, inst_cnt, exp_cnt);
        check({tag, "_done_valid"}, {31'd0, bus.idu_valid}, 32'd0);
    endtask

    initial begin
        tests_run      = 0;
        tests_failed   = 0;
        exp_cnt        = 0;
        reset          = 1'b1;
        bus.wbu_valid  = 1'b0;
        bus.wbu_jump   = 1'b0;
        bus.wbu_branch = 1'b0;
        bus.wbu_dnpc   = 32'h0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
        bus.mem_err    = 1'b0;
        bus.idu_ready  = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        // Reset state
        check("rst_wbu_ready", {31'd0, bus.wbu_ready}, 32'd1);
        check("rst_mem_req",   {31'd0, bus.mem_req},   32'd0);
        check("rst_idu_valid", {31'd0, bus.idu_valid}, 32'd0);
        check("rst_idu_inst",  bus.idu_inst,           32'h0);
        check("rst_idu_err",   {31'd0, bus.idu_err},   32'd0);
        check("rst_inst_cnt",  inst_cnt,               32'd0);
        check("rst_pc",        bus.mem_addr,           32'h8000_0000);

        //     tag        jump  br    dnpc           exp_addr       rdata          err  wait hold
        fetch("first",    1'b0, 1'b0, 32'h0,         32'h8000_0000, 32'h0000_0413, 1'b0, 0, 0);
        fetch("seq",      1'b0, 1'b0, 32'h0,         32'h8000_0004, 32'h0010_0093, 1'b0, 2, 1);
        fetch("branch",   1'b0, 1'b1, 32'h8000_0100, 32'h8000_0100, 32'h0020_0113, 1'b0, 0, 0);
        fetch("seq2",     1'b0, 1'b0, 32'h0,         32'h8000_0104, 32'h0030_0193, 1'b0, 1, 0);
        fetch("misalign", 1'b1, 1'b0, 32'h8000_0102, 32'h8000_0102, 32'h1111_1111, 1'b0, 0, 0);
        fetch("memerr",   1'b1, 1'b0, 32'h8000_0200, 32'h8000_0200, 32'hDEAD_BEEF, 1'b1, 0, 5);
        fetch("wrap_a",   1'b1, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0040_0213, 1'b0, 0, 0);
        fetch("wrap_b",   1'b0, 1'b0, 32'h0,         32'h0000_0000, 32'h0050_0293, 1'b0, 0, 0);

        // Reset while in WAIT, then a late response arrives in IDLE
        bus.wbu_valid = 1'b1;
        @(negedge clock);
        bus.wbu_valid = 1'b0;
        @(negedge clock);
        check("midrst_in_wait", {31'd0, bus.mem_req}, 32'd0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h1234_5678;
        @(negedge clock);
        bus.mem_rvalid = 1'b0;
        @(negedge clock);
        exp_cnt = 0;
        check("midrst_wbu_ready", {31'd0, bus.wbu_ready}, 32'd1);
        check("midrst_idu_valid", {31'd0, bus.idu_valid}, 32'd0);
        check("midrst_idu_inst",  bus.idu_inst,           32'h0);
        check("midrst_inst_cnt",  inst_cnt,               32'd0);

        // First token after reset fetches the reset PC even if it redirects
        fetch("post_rst", 1'b1, 1'b0, 32'h8000_0300, 32'h8000_0000, 32'h0060_0313, 1'b0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_ysyx_24080006_ifu

// File: doc/ysyx_24080006_ifu.md
YSYX_24080006_IFU -- requirements
Module: ysyx_24080006_ifu

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000, address of the first fetch after reset.
REQ-002 SHALL have parameter ILLEGAL_INST, default 32'h0000_0000, instruction word presented on a fetch error.
REQ-003 SHALL have port clock  input  1  system clock, rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port wbu_valid  input  1  writeback token offered.
REQ-006 SHALL have port wbu_ready  output  1  writeback token accepted when high with wbu_valid.
REQ-007 SHALL have port wbu_dnpc  input  32  redirect target.
REQ-008 SHALL have ports wbu_jump and wbu_branch  input  1 each  redirect taken flags.
REQ-009 SHALL have ports mem_req  output  1, mem_addr  output  32, mem_rvalid  input  1, mem_rdata  input  32, mem_err  input  1; these form the instruction memory read port.
REQ-010 SHALL have ports idu_valid  output  1, idu_ready  input  1, idu_inst  output  32, idu_pc  output  32, idu_err  output  1; these form the decode handoff.
REQ-011 SHALL have port inst_cnt  output  32  count of instructions handed to decode.

Function
REQ-012 SHALL implement FSM states IDLE, REQ, WAIT, HOLD.
REQ-013 IDLE: wbu_ready=1; on wbu_valid go to REQ, else stay in IDLE. wbu_ready SHALL be 0 in all other states.
REQ-014 On an IDLE accept, pc SHALL update as follows: first accept after reset: pc unchanged (RESET_PC); else if wbu_jump|wbu_branch: pc<=wbu_dnpc; else pc<=pc+4 (mod 2^32, wraps silently).
REQ-015 REQ: mem_req=1 and mem_addr=pc for exactly one cycle, then go to WAIT.
REQ-016 REQ with pc[1:0]!=0: mem_req SHALL stay 0; go directly to HOLD with idu_err=1 and idu_inst=ILLEGAL_INST.
REQ-017 WAIT: mem_rvalid is sampled only in this state; on mem_rvalid latch mem_rdata (or ILLEGAL_INST if mem_err) and err into idu registers and go to HOLD; else stay in WAIT indefinitely.
REQ-018 HOLD: idu_valid=1 with idu_inst, idu_pc=pc, and idu_err held stable; on idu_ready go to IDLE and increment inst_cnt (wraps at 2^32).
REQ-019 Latency: accept at cycle T -> mem_req at T+1 -> mem_rvalid earliest T+2 -> idu_valid at T+3.
REQ-020 mem_rvalid arriving outside WAIT SHALL be ignored with no state change.
REQ-021 idu_valid, mem_req, and wbu_ready SHALL be Moore outputs decoded from state only.
REQ-022 Only one fetch SHALL be outstanding at any time; no new wbu accept occurs until the decode handshake completes.

Reset
REQ-023 On reset: state=IDLE, pc=RESET_PC, first flag=1, idu_inst=0, idu_err=0, inst_cnt=0, mem_req=0, idu_valid=0.
REQ-024 Reset asserted mid-fetch SHALL abandon the transaction; a late mem_rvalid after reset SHALL be ignored per REQ-020.

Structure
REQ-025 The state enum, RESET_PC default, and ILLEGAL_INST default SHALL reside in shared package ysyx_24080006_pkg.
REQ-026 SHALL be a single module with no sub-modules; the pc register and next-pc mux are inline.

Verification
REQ-027 Reset, then wbu_valid=1 with dnpc=0 -> mem_addr=32'h8000_0000 at T+1; rdata=32'h0000_0413 -> idu_inst=32'h0000_0413, idu_pc=32'h8000_0000, inst_cnt=1.
REQ-028 Sequential token (jump=0, branch=0) -> mem_addr=32'h8000_0004.
REQ-029 Token with branch=1, dnpc=32'h8000_0100 -> mem_addr=32'h8000_0100; next sequential fetch -> 32'h8000_0104.
REQ-030 Jump to dnpc=32'h8000_0102 -> no mem_req, idu_valid=1 with idu_err=1 and idu_inst=32'h0.
REQ-031 mem_rvalid=1 with mem_err=1 -> idu_err=1 and idu_inst=ILLEGAL_INST; idu_ready held 0 for 5 cycles -> outputs stable and wbu_ready=0 throughout.
REQ-032 Reset pulsed while in WAIT, then stray mem_rvalid -> state stays IDLE, inst_cnt=0, next fetch at 32'h8000_0000.
